bypass_chain_loader: RTL and testbench

- Upstream driver of the wake-up bypass shift chain, which is a 24-bit serial stage1 register plus a parallel stage2 latch in the always-on domain.
- Accepts a parallel bypass word from the SoC control register file and shifts it MSB-first into the chain.
- Pulses the chain's latch strobe so the new power/isolation/memory overrides take effect in one step.
- Captures the previous stage1 contents from the chain's serial output as readback.

---
 rtl/bypass_chain_loader.sv | 186 ++++++++++++++++++
 tb/tb_bypass_chain_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_chain_loader.sv
// bypass_chain_loader
//   Drives the wake-up bypass shift chain (serial stage1 + parallel stage2 in
//   the always-on domain). A parallel word is shifted MSB-first into the chain
//   at a paced rate, then the stage2 latch strobe is pulsed once. The old
//   stage1 contents, which come back on the chain's serial output, are
//   returned as rdata_o.
//
//   Optional feature macro: BYPASS_LOADER_VERIFY_EN
//     When defined, a second paced pass re-shifts the same word and compares
//     the returned bits against it. Any difference sets the sticky mismatch_o.
//     When undefined, mismatch_o is tied low.
//
//   Ports
//     clk_i, rstn_i          clock, asynchronous active-low reset
//     req_i, wdata_i         load request / word (accepted when ready_o=1)
//     abort_i                cancel an in-progress shift pass
//     ready_o, done_o        idle indication / one-cycle completion pulse
//     rdata_o                previous stage1 word from the last completed load
//     mismatch_o             verify-pass error flag
//     wu_bypass_data_out_o   serial data to the chain
//     wu_bypass_en_o         chain shift enable
//     wu_bypass_shift_o      chain stage2 latch strobe
//     wu_bypass_data_in_i    serial data returned from the chain (stage1 MSB)
module bypass_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int DIV       = 1,
  parameter int DIV_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req_i,
  input  logic [CHAIN_LEN-1:0] wdata_i,
  input  logic                 abort_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [CHAIN_LEN-1:0] rdata_o,
  output logic                 mismatch_o,
  output logic                 wu_bypass_data_out_o,
  output logic                 wu_bypass_en_o,
  output logic                 wu_bypass_shift_o,
  input  logic                 wu_bypass_data_in_i
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_LATCH  = 3'd2,
`ifdef BYPASS_LOADER_VERIFY_EN
    ST_VERIFY = 3'd4,
`endif
    ST_DONE   = 3'd3
  } state_e;

  state_e                 state_q;
  logic [CHAIN_LEN-1:0]   sreg_q;
  logic [CHAIN_LEN-1:0]   cap_q;
  logic [CHAIN_LEN-1:0]   rdata_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DIV_W-1:0]       div_cnt_q;
  logic                   tick_s;
`ifdef BYPASS_LOADER_VERIFY_EN
  logic [CHAIN_LEN-1:0]   copy_q;
  logic                   mismatch_q;
`endif

  // Pacing tick comes straight from the counter flop, so outputs stay Moore.
  assign tick_s  = (div_cnt_q == DIV_LAST);
  assign rdata_o = rdata_q;
`ifdef BYPASS_LOADER_VERIFY_EN
  assign mismatch_o = mismatch_q;
`else
  assign mismatch_o = 1'b0;
`endif

  // Chain-facing and handshake outputs decoded from state and counter flops.
  always_comb begin
    ready_o              = 1'b0;
    done_o               = 1'b0;
    wu_bypass_en_o       = 1'b0;
    wu_bypass_shift_o    = 1'b0;
    wu_bypass_data_out_o = 1'b0;
    case (state_q)
      ST_IDLE:   ready_o = 1'b1;
      ST_SHIFT: begin
        wu_bypass_en_o       = tick_s;
        wu_bypass_data_out_o = sreg_q[CHAIN_LEN-1];
      end
      // Enable stays low while the strobe is high.
      ST_LATCH:  wu_bypass_shift_o = 1'b1;
      ST_DONE:   done_o = 1'b1;
`ifdef BYPASS_LOADER_VERIFY_EN
      ST_VERIFY: begin
        wu_bypass_en_o       = tick_s;
        wu_bypass_data_out_o = copy_q[CHAIN_LEN-1];
      end
`endif
      default:   ready_o = 1'b0;
    endcase
  end

  // Load FSM with shift/capture datapath and pacing counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
`ifdef BYPASS_LOADER_VERIFY_EN
      copy_q     <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            sreg_q    <= wdata_i;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            state_q   <= ST_SHIFT;
`ifdef BYPASS_LOADER_VERIFY_EN
            copy_q     <= wdata_i;
            mismatch_q <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            // A shift on the abort cycle still completes at this edge.
            div_cnt_q <= '0;
            sreg_q    <= {sreg_q[CHAIN_LEN-2:0], 1'b0};
            cap_q     <= {cap_q[CHAIN_LEN-2:0], wu_bypass_data_in_i};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (tick_s && (bit_cnt_q == LAST_BIT)) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          bit_cnt_q <= '0;
          div_cnt_q <= '0;
`ifdef BYPASS_LOADER_VERIFY_EN
          state_q   <= ST_VERIFY;
`else
          state_q   <= ST_DONE;
`endif
        end
`ifdef BYPASS_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (tick_s) begin
            // Stage1 now holds the written word, so its MSB must match ours.
            if (wu_bypass_data_in_i != copy_q[CHAIN_LEN-1]) begin
              mismatch_q <= 1'b1;
            end
            div_cnt_q <= '0;
            copy_q    <= {copy_q[CHAIN_LEN-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (tick_s && (bit_cnt_q == LAST_BIT)) begin
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          rdata_q <= cap_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_chain_loader.sv
module tb_bypass_chain_loader;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         rstn    [2];
  logic         req     [2];
  logic [N-1:0] wdata   [2];
  logic         abort   [2];
  logic         ready   [2];
  logic         done    [2];
  logic [N-1:0] rdata   [2];
  logic         mism    [2];
  logic         dout    [2];
  logic         en      [2];
  logic         sh      [2];
  logic         din     [2];

  // Behavioural chain: stage1 shift register and stage2 latch.
  logic [N-1:0] st1 [2];
  logic [N-1:0] st2 [2];
  logic         fz  [2];
  logic         init_done;
  logic [N-1:0] seed1;

  logic [N-1:0] exp_rdata [2];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bypass_chain_loader #(.CHAIN_LEN(N), .DIV(1), .DIV_W(8)) u_div1 (
    .clk_i(clk), .rstn_i(rstn[0]), .req_i(req[0]), .wdata_i(wdata[0]),
    .abort_i(abort[0]), .ready_o(ready[0]), .done_o(done[0]),
    .rdata_o(rdata[0]), .mismatch_o(mism[0]),
    .wu_bypass_data_out_o(dout[0]), .wu_bypass_en_o(en[0]),
    .wu_bypass_shift_o(sh[0]), .wu_bypass_data_in_i(din[0]));

  bypass_chain_loader #(.CHAIN_LEN(N), .DIV(3), .DIV_W(8)) u_div3 (
    .clk_i(clk), .rstn_i(rstn[1]), .req_i(req[1]), .wdata_i(wdata[1]),
    .abort_i(abort[1]), .ready_o(ready[1]), .done_o(done[1]),
    .rdata_o(rdata[1]), .mismatch_o(mism[1]),
    .wu_bypass_data_out_o(dout[1]), .wu_bypass_en_o(en[1]),
    .wu_bypass_shift_o(sh[1]), .wu_bypass_data_in_i(din[1]));

  assign din[0] = fz[0] ? 1'b0 : st1[0][N-1];
  assign din[1] = fz[1] ? 1'b0 : st1[1][N-1];

  // Chain model update on the DUT clock.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!init_done) begin
        st1[u] <= (u == 0) ? '0 : seed1;
        st2[u] <= '0;
      end else begin
        if (en[u]) st1[u] <= {st1[u][N-2:0], dout[u]};
        if (sh[u]) st2[u] <= st1[u];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Expected enable: one pulse every d cycles for each of the N shifts.
  function automatic bit is_en(input int c, input int d);
    int m;
    if ((c % d == 0) && (c / d >= 1) && (c / d <= N)) return 1'b1;
`ifdef BYPASS_LOADER_VERIFY_EN
    m = c - (N * d + 1);
    if ((m > 0) && (m % d == 0) && (m / d <= N)) return 1'b1;
`endif
    m = 0;
    return (m != 0);
  endfunction

  task automatic run_load(input int u, input logic [N-1:0] w, input int abort_c,
                          input int rst_c, input bit hold_req, input bit force_v);
    int d, busy, end_c, n_sh;
    int e_en, e_sh, e_dn, e_rd;
    bit live, xe, xs, xd, xr, exp_m;
    logic [N-1:0] old1, old2, seq;
    logic [2*N-1:0] cat;
    d = div_of(u);
`ifdef BYPASS_LOADER_VERIFY_EN
    busy = 2 * N * d + 2;
`else
    busy = N * d + 2;
`endif
    end_c = (abort_c > 0) ? abort_c + 1 : (rst_c > 0) ? rst_c : busy + 1;
    e_en = 0; e_sh = 0; e_dn = 0; e_rd = 0; seq = '0;
    @(negedge clk);
    old1 = st1[u]; old2 = st2[u];
    req[u] = 1'b1; wdata[u] = w;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      if (hold_req && c == 1) wdata[u] = ~w;
      if (!hold_req || c >= 4) req[u] = 1'b0;
      abort[u] = (c == abort_c);
      fz[u] = force_v && (c > N * d + 1);
      if (c == rst_c) begin
        rstn[u] = 1'b0;
        #1;
        check_eq("rst_en", 32'(en[u]), 32'd0);
        check_eq("rst_shift", 32'(sh[u]), 32'd0);
        check_eq("rst_done", 32'(done[u]), 32'd0);
        check_eq("rst_ready", 32'(ready[u]), 32'd1);
        check_eq("rst_rdata", 32'(rdata[u]), 32'd0);
      end else begin
        live = (abort_c == 0) || (c <= abort_c);
        xe = live && is_en(c, d);
        xs = live && (c == N * d + 1);
        xd = live && (c == busy);
        xr = !live || (c > busy);
        if (en[u] !== xe) e_en++;
        if (sh[u] !== xs) e_sh++;
        if (done[u] !== xd) e_dn++;
        if (ready[u] !== xr) e_rd++;
        if (en[u] === 1'b1) seq = {seq[N-2:0], dout[u]};
      end
    end
    abort[u] = 1'b0; fz[u] = 1'b0; req[u] = 1'b0;
    check_eq("en_pattern", 32'(e_en), 32'd0);
    check_eq("latch_pattern", 32'(e_sh), 32'd0);
    check_eq("done_pattern", 32'(e_dn), 32'd0);
    check_eq("ready_pattern", 32'(e_rd), 32'd0);
    if (rst_c > 0) begin
      @(negedge clk);
      rstn[u] = 1'b1;
      exp_rdata[u] = '0;
      n_sh = (rst_c - 1) / d;
      cat = {old1, w} << n_sh;
      check_eq("rst_stage2", 32'(st2[u]), 32'(old2));
      check_eq("rst_stage1", 32'(st1[u]), 32'(cat[2*N-1:N]));
    end else if (abort_c > 0) begin
      n_sh = abort_c / d;
      cat = {old1, w} << n_sh;
      check_eq("abort_rdata", 32'(rdata[u]), 32'(exp_rdata[u]));
      check_eq("abort_stage2", 32'(st2[u]), 32'(old2));
      check_eq("abort_stage1", 32'(st1[u]), 32'(cat[2*N-1:N]));
    end else begin
      exp_rdata[u] = old1;
      exp_m = 1'b0;
`ifdef BYPASS_LOADER_VERIFY_EN
      exp_m = force_v && (w != '0);
`endif
      check_eq("dout_seq", 32'(seq), 32'(w));
      check_eq("rdata", 32'(rdata[u]), 32'(old1));
      check_eq("stage2", 32'(st2[u]), 32'(w));
      check_eq("stage1", 32'(st1[u]), 32'(w));
      check_eq("mismatch", 32'(mism[u]), 32'(exp_m));
    end
  endtask

  initial begin
    init_done = 1'b0;
    seed1 = N'($urandom);
    for (int u = 0; u < 2; u++) begin
      rstn[u] = 1'b0; req[u] = 1'b0; wdata[u] = '0; abort[u] = 1'b0;
      fz[u] = 1'b0; exp_rdata[u] = '0;
    end
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    for (int u = 0; u < 2; u++) rstn[u] = 1'b1;
    @(negedge clk);

    // Reset state on both instances.
    for (int u = 0; u < 2; u++) begin
      check_eq("reset_ready", 32'(ready[u]), 32'd1);
      check_eq("reset_done", 32'(done[u]), 32'd0);
      check_eq("reset_rdata", 32'(rdata[u]), 32'd0);
      check_eq("reset_en", 32'(en[u]), 32'd0);
      check_eq("reset_shift", 32'(sh[u]), 32'd0);
      check_eq("reset_mismatch", 32'(mism[u]), 32'd0);
    end

    // Abort while idle has no effect.
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check_eq("idle_abort_ready", 32'(ready[0]), 32'd1);
    check_eq("idle_abort_en", 32'(en[0]), 32'd0);

    // Directed words, DIV=1.
    run_load(0, 24'hA5F00F, 0, 0, 1'b0, 1'b0);
    run_load(0, 24'h123456, 0, 0, 1'b0, 1'b0);
    check_eq("rdata_prev_word", 32'(rdata[0]), 32'h00A5F00F);

    // DIV=3 loads.
    run_load(1, N'($urandom), 0, 0, 1'b0, 1'b0);
    run_load(1, N'($urandom), 0, 0, 1'b0, 1'b0);

    // Request held high and data changed while busy: single load only.
    run_load(0, N'($urandom), 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("no_requeue_ready", 32'(ready[0]), 32'd1);

    // Abort after 10 shifts, then a normal load.
    run_load(0, N'($urandom), 10, 0, 1'b0, 1'b0);
    run_load(0, N'($urandom), 0, 0, 1'b0, 1'b0);

    // Reset in cycle 12 of SHIFT, then a normal load.
    run_load(0, N'($urandom), 0, 12, 1'b0, 1'b0);
    run_load(0, N'($urandom), 0, 0, 1'b0, 1'b0);

    // Abort on the slower instance mid-stream.
    run_load(1, N'($urandom), 3 * 7 + 1, 0, 1'b0, 1'b0);

    // Randomized loads on both instances.
    for (int i = 0; i < 3; i++) begin
      run_load(0, N'($urandom), 0, 0, 1'b0, 1'b0);
      run_load(1, N'($urandom), 0, 0, 1'b0, 1'b0);
    end

`ifdef BYPASS_LOADER_VERIFY_EN
    // Forced-zero return during verify, then a clean load clears the flag.
    run_load(0, 24'hFFFFFF, 0, 0, 1'b0, 1'b1);
    run_load(0, N'($urandom), 0, 0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
